// File: rtl/param_expr_stack_pkg.sv
// es_pkg: shared encodings for the expression stack.
//   es_op_e     - ESOp codes (6 and 7 are treated as NOP)
//   push_src_e  - pushSrc codes (0-3 select the literal value itself)
//   OP_W/SRC_W  - field widths used by the interface and sub-modules
package es_pkg;

    localparam int OP_W  = 3;
    localparam int SRC_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_NOP   = 3'd0,
        OP_PUSH  = 3'd1,
        OP_POP   = 3'd2,
        OP_DUP   = 3'd3,
        OP_SWAP  = 3'd4,
        OP_CLEAR = 3'd5
    } es_op_e;

    typedef enum logic [SRC_W-1:0] {
        SRC_LIT0  = 3'd0,
        SRC_LIT1  = 3'd1,
        SRC_LIT2  = 3'd2,
        SRC_LIT3  = 3'd3,
        SRC_EXT   = 3'd4,
        SRC_IMM   = 3'd5,
        SRC_SNAPA = 3'd6,
        SRC_SNAPB = 3'd7
    } push_src_e;

endpackage

// File: rtl/param_expr_stack_if.sv
// param_expr_stack_if: operation and status bundle of the expression stack.
// Handshake: there is no back-pressure. The master presents ESOp/pushSrc/
// operands with ESAct=1 for exactly the cycles it wants an op executed; the
// stack always accepts in that cycle and the result is visible on the
// status outputs the cycle after the edge. snap is an independent strobe.
//   master: drives ESAct, ESOp, pushSrc, ext_data, imm, snap
//   slave : drives tos_a, tos_b, depth, full, empty, ovf_err, unf_err
interface param_expr_stack_if
    import es_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             ESAct;
    logic [OP_W-1:0]  ESOp;
    logic [SRC_W-1:0] pushSrc;
    logic [WIDTH-1:0] ext_data;
    logic [WIDTH-1:0] imm;
    logic             snap;
    logic [WIDTH-1:0] tos_a;
    logic [WIDTH-1:0] tos_b;
    logic [CW-1:0]    depth;
    logic             full;
    logic             empty;
    logic             ovf_err;
    logic             unf_err;

    modport master (
        output ESAct, ESOp, pushSrc, ext_data, imm, snap,
        input  tos_a, tos_b, depth, full, empty, ovf_err, unf_err
    );

    modport slave (
        input  ESAct, ESOp, pushSrc, ext_data, imm, snap,
        output tos_a, tos_b, depth, full, empty, ovf_err, unf_err
    );

endinterface

// File: rtl/param_expr_stack_push_sel.sv
// es_push_sel: combinational PUSH operand selector.
//   pushSrc  in  source code (0-3 literal, 4 ext_data, 5 imm, 6 snapA, 7 snapB)
//   ext_data/imm/snapA/snapB  in  candidate operands
//   push_val out selected value, literals zero-extended to WIDTH
module es_push_sel
    import es_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [SRC_W-1:0] pushSrc,
    input  logic [WIDTH-1:0] ext_data,
    input  logic [WIDTH-1:0] imm,
    input  logic [WIDTH-1:0] snapA,
    input  logic [WIDTH-1:0] snapB,
    output logic [WIDTH-1:0] push_val
);

    always_comb begin
        push_val = '0;
        case (push_src_e'(pushSrc))
            SRC_EXT:   push_val = ext_data;
            SRC_IMM:   push_val = imm;
            SRC_SNAPA: push_val = snapA;
            SRC_SNAPB: push_val = snapB;
            default:   push_val[1:0] = pushSrc[1:0];
        endcase
    end

endmodule

// File: rtl/param_expr_stack.sv
// param_expr_stack: single-cycle DEPTH x WIDTH operand stack with
// PUSH/POP/DUP/SWAP/CLEAR and two snapshot registers.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   es (slave) : op strobe/code, push source and operands, snap strobe;
//                tos_a/tos_b (masked to 0 beyond depth), depth, full,
//                empty, sticky ovf_err/unf_err
// Build option: define ES_ERR_FLAGS_EN to build the sticky error flags;
// otherwise ovf_err/unf_err are constant 0 (illegal ops are still blocked).
module param_expr_stack
    import es_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    param_expr_stack_if.slave   es
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [CW-1:0]    depth_q, depth_d;
    logic [WIDTH-1:0] snap_a_q, snap_a_d;
    logic [WIDTH-1:0] snap_b_q, snap_b_d;

    logic [WIDTH-1:0] tos_a, tos_b, push_val;
    logic [AW-1:0]    wr_idx, top_idx, sec_idx;
    logic             is_full, is_empty, has_two;
    logic             ovf_hit, unf_hit, clr_hit;

    // Entry i holds the (i+1)-th pushed value; the top lives at depth-1.
    assign wr_idx   = AW'(depth_q);
    assign top_idx  = AW'(depth_q - CW'(1));
    assign sec_idx  = AW'(depth_q - CW'(2));
    assign is_full  = (depth_q == CW'(DEPTH));
    assign is_empty = (depth_q == '0);
    assign has_two  = (depth_q >= CW'(2));

    // Storage is never reset, so anything above depth is masked here.
    assign tos_a = is_empty ? '0 : mem_q[top_idx];
    assign tos_b = has_two  ? mem_q[sec_idx] : '0;

    // Snapshot registers feed the selector with their pre-edge value.
    es_push_sel #(.WIDTH(WIDTH)) u_push_sel (
        .pushSrc  (es.pushSrc),
        .ext_data (es.ext_data),
        .imm      (es.imm),
        .snapA    (snap_a_q),
        .snapB    (snap_b_q),
        .push_val (push_val)
    );

    always_comb begin
        mem_d    = mem_q;
        depth_d  = depth_q;
        ovf_hit  = 1'b0;
        unf_hit  = 1'b0;
        clr_hit  = 1'b0;
        snap_a_d = es.snap ? tos_a : snap_a_q;
        snap_b_d = es.snap ? tos_b : snap_b_q;
        if (es.ESAct) begin
            case (es_op_e'(es.ESOp))
                OP_PUSH: begin
                    if (is_full) begin
                        ovf_hit = 1'b1;
                    end else begin
                        mem_d[wr_idx] = push_val;
                        depth_d       = depth_q + CW'(1);
                    end
                end
                OP_POP: begin
                    if (is_empty) unf_hit = 1'b1;
                    else          depth_d = depth_q - CW'(1);
                end
                OP_DUP: begin
                    // Empty is checked first: DUP on empty is an underflow.
                    if (is_empty) begin
                        unf_hit = 1'b1;
                    end else if (is_full) begin
                        ovf_hit = 1'b1;
                    end else begin
                        mem_d[wr_idx] = tos_a;
                        depth_d       = depth_q + CW'(1);
                    end
                end
                OP_SWAP: begin
                    if (!has_two) begin
                        unf_hit = 1'b1;
                    end else begin
                        mem_d[top_idx] = mem_q[sec_idx];
                        mem_d[sec_idx] = mem_q[top_idx];
                    end
                end
                OP_CLEAR: begin
                    depth_d = '0;
                    clr_hit = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            depth_q  <= '0;
            snap_a_q <= '0;
            snap_b_q <= '0;
        end else begin
            depth_q  <= depth_d;
            snap_a_q <= snap_a_d;
            snap_b_q <= snap_b_d;
        end
    end

    // Data array has no reset; a reset only zeroes depth.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

`ifdef ES_ERR_FLAGS_EN
    logic ovf_q, ovf_d;
    logic unf_q, unf_d;

    always_comb begin
        ovf_d = clr_hit ? 1'b0 : (ovf_q | ovf_hit);
        unf_d = clr_hit ? 1'b0 : (unf_q | unf_hit);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign es.ovf_err = ovf_q;
    assign es.unf_err = unf_q;
`else
    logic unused_err_hits;
    assign unused_err_hits = ovf_hit ^ unf_hit ^ clr_hit;
    assign es.ovf_err      = 1'b0;
    assign es.unf_err      = 1'b0;
`endif

    assign es.tos_a = tos_a;
    assign es.tos_b = tos_b;
    assign es.depth = depth_q;
    assign es.full  = is_full;
    assign es.empty = is_empty;

endmodule

// File: tb/tb_param_expr_stack.sv
// tb_param_expr_stack: directed scenarios plus randomized ops for
// param_expr_stack (WIDTH=16, DEPTH=4), compared against a queue-based
// reference stack. Works with or without ES_ERR_FLAGS_EN.
module tb_param_expr_stack;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

`ifdef ES_ERR_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    param_expr_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) es_if ();

    param_expr_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .es    (es_if)
    );

    // ---------------- reference model ----------------
    logic [WIDTH-1:0] exp_q [$];   // back of queue is top of stack
    logic [WIDTH-1:0] m_snap_a, m_snap_b;
    bit               m_ovf, m_unf;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_step(input bit rst, input bit act, input logic [2:0] op,
                              input logic [2:0] src, input logic [WIDTH-1:0] ext,
                              input logic [WIDTH-1:0] imv, input bit snp);
        logic [WIDTH-1:0] old_a, old_b, pv, tmp;
        int n;
        if (rst) begin
            exp_q.delete();
            m_ovf = 0; m_unf = 0;
            m_snap_a = '0; m_snap_b = '0;
            return;
        end
        n     = exp_q.size();
        old_a = (n > 0) ? exp_q[n-1] : '0;
        old_b = (n > 1) ? exp_q[n-2] : '0;
        case (src)
            3'd4:    pv = ext;
            3'd5:    pv = imv;
            3'd6:    pv = m_snap_a;
            3'd7:    pv = m_snap_b;
            default: begin pv = '0; pv[2:0] = src; end
        endcase
        if (act) begin
            case (op)
                3'd1: if (n < DEPTH) exp_q.push_back(pv); else m_ovf = 1;
                3'd2: if (n > 0) void'(exp_q.pop_back()); else m_unf = 1;
                3'd3: begin
                    if (n == 0)          m_unf = 1;
                    else if (n == DEPTH) m_ovf = 1;
                    else                 exp_q.push_back(old_a);
                end
                3'd4: begin
                    if (n < 2) m_unf = 1;
                    else begin
                        tmp = exp_q[n-1]; exp_q[n-1] = exp_q[n-2]; exp_q[n-2] = tmp;
                    end
                end
                3'd5: begin exp_q.delete(); m_ovf = 0; m_unf = 0; end
                default: ;
            endcase
        end
        if (snp) begin
            m_snap_a = old_a;
            m_snap_b = old_b;
        end
    endtask

    task automatic check_all(input string tag);
        logic [WIDTH-1:0] ea, eb;
        int n;
        n  = exp_q.size();
        ea = (n > 0) ? exp_q[n-1] : '0;
        eb = (n > 1) ? exp_q[n-2] : '0;
        chk({tag, ".tos_a"},   32'(es_if.tos_a),   32'(ea));
        chk({tag, ".tos_b"},   32'(es_if.tos_b),   32'(eb));
        chk({tag, ".depth"},   32'(es_if.depth),   32'(n));
        chk({tag, ".full"},    32'(es_if.full),    32'(n == DEPTH));
        chk({tag, ".empty"},   32'(es_if.empty),   32'(n == 0));
        chk({tag, ".ovf_err"}, 32'(es_if.ovf_err), 32'(FLAGS & m_ovf));
        chk({tag, ".unf_err"}, 32'(es_if.unf_err), 32'(FLAGS & m_unf));
    endtask

    // ---------------- driver ----------------
    task automatic drive(input string tag, input bit rst, input bit act, input logic [2:0] op,
                         input logic [2:0] src, input logic [WIDTH-1:0] ext,
                         input logic [WIDTH-1:0] imv, input bit snp);
        @(negedge clk);
        reset          = rst;
        es_if.ESAct    = act;
        es_if.ESOp     = op;
        es_if.pushSrc  = src;
        es_if.ext_data = ext;
        es_if.imm      = imv;
        es_if.snap     = snp;
        model_step(rst, act, op, src, ext, imv, snp);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic op_(input string tag, input logic [2:0] op, input logic [2:0] src,
                       input logic [WIDTH-1:0] ext);
        drive(tag, 1'b0, 1'b1, op, src, ext, '0, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset          = 1'b1;
        es_if.ESAct    = 1'b0;
        es_if.ESOp     = '0;
        es_if.pushSrc  = '0;
        es_if.ext_data = '0;
        es_if.imm      = '0;
        es_if.snap     = 1'b0;

        drive("rst0", 1'b1, 1'b0, 3'd0, 3'd0, '0, '0, 1'b0);
        drive("rst1", 1'b1, 1'b1, 3'd1, 3'd3, '0, '0, 1'b0);
        chk("rst.depth", 32'(es_if.depth), 32'd0);
        chk("rst.empty", 32'(es_if.empty), 32'd1);

        // push literal 3, then external 0xBEEF
        op_("p_lit3", 3'd1, 3'd3, '0);
        op_("p_ext", 3'd1, 3'd4, 16'hBEEF);
        chk("r35.tos_a", 32'(es_if.tos_a), 32'h0000BEEF);
        chk("r35.tos_b", 32'(es_if.tos_b), 32'h00000003);
        chk("r35.depth", 32'(es_if.depth), 32'd2);

        // swap then pop
        op_("swap", 3'd4, 3'd0, '0);
        op_("pop", 3'd2, 3'd0, '0);
        chk("r36.tos_a", 32'(es_if.tos_a), 32'h0000BEEF);
        chk("r36.tos_b", 32'(es_if.tos_b), 32'h0);
        chk("r36.depth", 32'(es_if.depth), 32'd1);

        // fill, overflow with imm, then clear
        op_("clr0", 3'd5, 3'd0, '0);
        for (int i = 1; i <= 4; i++) op_("fill", 3'd1, 3'd4, 16'(i * 'h11));
        drive("ovf_imm", 1'b0, 1'b1, 3'd1, 3'd5, '0, 16'h0055, 1'b0);
        chk("r37.depth", 32'(es_if.depth), 32'd4);
        chk("r37.tos_a", 32'(es_if.tos_a), 32'h44);
        chk("r37.full",  32'(es_if.full), 32'd1);
        chk("r37.ovf",   32'(es_if.ovf_err), 32'(FLAGS));
        op_("clr1", 3'd5, 3'd0, '0);
        chk("r37.clr_depth", 32'(es_if.depth), 32'd0);
        chk("r37.clr_ovf",   32'(es_if.ovf_err), 32'd0);

        // underflow: pop and dup on empty
        op_("pop_e", 3'd2, 3'd0, '0);
        op_("dup_e", 3'd3, 3'd0, '0);
        chk("r38.depth", 32'(es_if.depth), 32'd0);
        chk("r38.unf",   32'(es_if.unf_err), 32'(FLAGS));
        chk("r38.ovf",   32'(es_if.ovf_err), 32'd0);

        // snapshot ordering against same-edge push
        op_("clr2", 3'd5, 3'd0, '0);
        op_("p_0b", 3'd1, 3'd4, 16'h000B);
        op_("p_0a", 3'd1, 3'd4, 16'h000A);
        drive("snap_push", 1'b0, 1'b1, 3'd1, 3'd6, '0, '0, 1'b1);
        chk("r39.old_snapA", 32'(es_if.tos_a), 32'h0);
        op_("p_snapB", 3'd1, 3'd7, '0);
        chk("r39.snapB", 32'(es_if.tos_a), 32'h0B);

        // ESAct low and NOP codes must not change the stack
        drive("act0", 1'b0, 1'b0, 3'd1, 3'd4, 16'h1234, '0, 1'b0);
        op_("nop6", 3'd6, 3'd4, 16'h1234);

        // reset during a push at depth 3
        op_("pop_d3", 3'd2, 3'd0, '0);
        chk("r40.pre_depth", 32'(es_if.depth), 32'd3);
        drive("rst_push", 1'b1, 1'b1, 3'd1, 3'd4, 16'h7777, '0, 1'b0);
        chk("r40.depth", 32'(es_if.depth), 32'd0);
        chk("r40.empty", 32'(es_if.empty), 32'd1);
        chk("r40.tos_a", 32'(es_if.tos_a), 32'h0);

        // randomized ops
        for (int k = 0; k < 400; k++) begin
            drive("rnd",
                  ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 9) != 0),
                  3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)),
                  16'($urandom),
                  16'($urandom),
                  ($urandom_range(0, 3) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/param_expr_stack.md
PARAM_EXPR_STACK -- requirements
Module: param_expr_stack

Interface
REQ-001 Parameter WIDTH, default 16, data word width in bits (>=4).
REQ-002 Parameter DEPTH, default 8, stack entries (>=2); CW = $clog2(DEPTH+1).
REQ-003 The block SHALL have one clock, clk, and a synchronous, active-high reset, reset.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 ESAct  in  1  op strobe; ESOp is acted on only in cycles where ESAct=1.
REQ-007 ESOp  in  3  op: 0 NOP, 1 PUSH, 2 POP, 3 DUP, 4 SWAP, 5 CLEAR, 6-7 NOP.
REQ-008 pushSrc  in  3  PUSH source: 0-3 literal value pushSrc, 4 ext_data, 5 imm, 6 snapA, 7 snapB.
REQ-009 ext_data  in  WIDTH  external push operand.
REQ-010 imm  in  WIDTH  immediate push operand.
REQ-011 snap  in  1  load snapshot registers snapA<=tos_a, snapB<=tos_b.
REQ-012 tos_a  out  WIDTH  top entry; 0 when depth=0.
REQ-013 tos_b  out  WIDTH  second entry; 0 when depth<2.
REQ-014 depth  out  CW  current entry count.
REQ-015 full / empty  out  1 each  depth==DEPTH / depth==0.
REQ-016 ovf_err / unf_err  out  1 each  sticky overflow / underflow flags.

Function
REQ-017 All ops SHALL complete in one clock; tos_a, tos_b, depth, full and empty reflect the result on the cycle after the ESAct edge.
REQ-018 PUSH with depth<DEPTH: new top = selected source value, depth+1; literals are zero-extended to WIDTH.
REQ-019 POP with depth>=1: depth-1; stored data below the top are unchanged.
REQ-020 DUP with 1<=depth<DEPTH: push a copy of tos_a; depth+1.
REQ-021 SWAP with depth>=2: exchange tos_a and tos_b; depth unchanged.
REQ-022 CLEAR: depth<=0 and ovf_err and unf_err <=0 regardless of current depth.
REQ-023 Illegal op (PUSH/DUP when full; POP when empty; DUP when empty; SWAP with depth<2) SHALL leave stack and depth unchanged.
REQ-024 An illegal op caused by fullness sets ovf_err; one caused by insufficient entries sets unf_err. DUP on empty sets unf_err.
REQ-025 snapA/snapB SHALL sample tos_a/tos_b as they are before any same-edge op, so snap plus PUSH pushSrc=6 in one cycle pushes the old snapA.
REQ-026 ESAct=0, or NOP codes, SHALL change nothing except the snapshot registers.
REQ-027 A push whose source is snapA/snapB SHALL use the register value at the edge, not the current tos_a/tos_b.

Reset
REQ-028 When reset=1 at a clock edge: depth=0, empty=1, full=0, ovf_err=0, unf_err=0, snapA=snapB=0; the ESAct op in the same cycle is ignored.
REQ-029 Storage array contents SHALL need no reset; outputs are masked to 0 per REQ-012/013.

Configuration
REQ-030 With macro ES_ERR_FLAGS_EN defined: ovf_err and unf_err behave per REQ-024 and REQ-022.
REQ-031 Without ES_ERR_FLAGS_EN: ovf_err and unf_err are tied to 0 and no flag registers are built; REQ-023 guarding still applies.

Structure
REQ-032 Shared package es_pkg SHALL hold ESOp and pushSrc encodings as typed enums/localparams.
REQ-033 The pushSrc selection SHALL be a sub-module es_push_sel (combinational; inputs pushSrc, ext_data, imm, snapA, snapB).
REQ-034 Stack storage SHALL be a DEPTH x WIDTH register array indexed by depth; no latches.

Verification (WIDTH=16, DEPTH=4)
REQ-035 Reset, then PUSH pushSrc=3, then PUSH pushSrc=4 with ext_data=0xBEEF -> tos_a=0xBEEF, tos_b=0x0003, depth=2.
REQ-036 From REQ-035 state, SWAP then POP -> tos_a=0xBEEF, tos_b=0, depth=1.
REQ-037 Push 4 values (0x11-0x44), then PUSH imm=0x55 -> depth=4, tos_a=0x44, full=1, ovf_err=1; then CLEAR -> depth=0, ovf_err=0.
REQ-038 From empty, POP then DUP -> depth=0, unf_err=1, ovf_err=0; with ES_ERR_FLAGS_EN undefined, both flags stay 0.
REQ-039 tos_a=0x0A, tos_b=0x0B; snap=1 and ESAct PUSH pushSrc=6 in the same cycle -> pushes the prior snapA (0); next cycle PUSH pushSrc=7 -> tos_a=0x0B.
REQ-040 Assert reset during a PUSH with depth=3 -> next cycle depth=0, empty=1, tos_a=0.
